// File: rtl/mac_pkg.sv
// Shared types and constants for the MAC accumulate stage: FSM state encoding,
// default widths and the iteration-counter width helper.
package mac_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MUL  = 2'd1,
      ACC  = 2'd2,
      DONE = 2'd3
   } state_t;

   localparam int DW_DEF = 16;
   localparam int AW_DEF = 32;

   // Counter must hold 0..n-1; keep at least one bit for degenerate n.
   function automatic int cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   localparam int CNT_W_DEF = cnt_width(DW_DEF);

endpackage

// File: rtl/cla.sv
// N-bit carry-lookahead adder: carries are looked ahead inside 4-bit groups,
// and each group's carry-in comes from the previous group's lookahead result.
module cla #(
   parameter int N = 32
) (
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   input  logic         cin,
   output logic [N-1:0] s,
   output logic         cout
);

   logic [N-1:0] g;
   logic [N-1:0] p;
   logic [N:0]   c;
   logic         term;
   logic         pall;

   assign g = a & b;
   assign p = a ^ b;

   // c[i+1] expands generate/propagate terms back to the carry entering the group.
   always_comb begin
      c    = '0;
      c[0] = cin;
      term = 1'b0;
      pall = 1'b1;
      for (int i = 0; i < N; i++) begin
         term = 1'b0;
         pall = 1'b1;
         for (int k = 0; k < 4; k++) begin
            if (k <= (i % 4)) begin
               term = term | (pall & g[i-k]);
               pall = pall & p[i-k];
            end
         end
         c[i+1] = term | (pall & c[i-(i%4)]);
      end
   end

   assign s    = p ^ c[N-1:0];
   assign cout = c[N];

endmodule

// File: rtl/mac_accumulate.sv
// Sequential multiply-accumulate: shift-add multiply of one operand pair, then a
// single add into the accumulator through cla. Define MAC_ACC_SATURATE_EN to clamp on carry-out.
//
// state | meaning
// IDLE  | in_ready=1, waiting for an operand pair
// MUL   | DW shift-add iterations building prod
// ACC   | prod added into accumulator, overflow updated
// DONE  | out_valid pulse, acc_out holds the new sum
module mac_accumulate
   import mac_pkg::*;
#(
   parameter int DW = DW_DEF,
   parameter int AW = AW_DEF
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [DW-1:0] a,
   input  logic [DW-1:0] b,
   input  logic          clr,
   output logic [AW-1:0] acc_out,
   output logic          out_valid,
   output logic          overflow
);

   localparam int CW = cnt_width(DW);
   localparam int PW = 2 * DW;

   if (AW < 2 * DW) begin : g_width_check
      $fatal(1, "mac_accumulate: AW (%0d) must be >= 2*DW (%0d)", AW, 2 * DW);
   end

   state_t        state;
   logic [PW-1:0] prod;
   logic [PW-1:0] mcand;
   logic [DW-1:0] mplier;
   logic [CW-1:0] cnt;
   logic          clr_q;

   logic [AW-1:0] add_a;
   logic [AW-1:0] add_b;
   logic [AW-1:0] sum;
   logic          cout;

   always_comb begin
      add_a = clr_q ? '0 : acc_out;
      add_b = AW'(prod);
   end

   cla #(.N(AW)) u_cla (
      .a    (add_a),
      .b    (add_b),
      .cin  (1'b0),
      .s    (sum),
      .cout (cout)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         prod     <= '0;
         mcand    <= '0;
         mplier   <= '0;
         cnt      <= '0;
         clr_q    <= 1'b0;
         acc_out  <= '0;
         overflow <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  mcand  <= PW'(a);
                  mplier <= b;
                  clr_q  <= clr;
                  prod   <= '0;
                  cnt    <= '0;
                  state  <= MUL;
               end
            end
            MUL: begin
               if (mplier[0]) begin
                  prod <= prod + mcand;
               end
               mcand  <= mcand << 1;
               mplier <= mplier >> 1;
               // Fixed DW iterations regardless of operand values.
               if (cnt == CW'(DW - 1)) begin
                  cnt   <= '0;
                  state <= ACC;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            ACC: begin
`ifdef MAC_ACC_SATURATE_EN
               acc_out <= cout ? '1 : sum;
`else
               acc_out <= sum;
`endif
               overflow <= clr_q ? cout : (overflow | cout);
               state    <= DONE;
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);

endmodule

// File: tb/tb_mac_accumulate.sv
// Self-checking bench for mac_accumulate: cycle-level reference model plus
// directed literal expectations and randomized operand traffic.
module tb_mac_accumulate;

   localparam int DW = 16;
   localparam int AW = 32;
   localparam int LAT = DW + 2;

   logic          clk = 1'b0;
   logic          rst;
   logic          in_valid;
   logic          in_ready;
   logic [DW-1:0] a;
   logic [DW-1:0] b;
   logic          clr;
   logic [AW-1:0] acc_out;
   logic          out_valid;
   logic          overflow;

   mac_accumulate #(.DW(DW), .AW(AW)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .clr       (clr),
      .acc_out   (acc_out),
      .out_valid (out_valid),
      .overflow  (overflow)
   );

   always #5 clk = ~clk;

   // Reference model: an accepted pair yields its result LAT cycles later;
   // busy for exactly LAT cycles after the accepting edge.
   bit          m_busy = 1'b0;
   int          m_k = 0;
   logic [31:0] m_acc = '0;
   bit          m_ovf = 1'b0;
   logic [31:0] p_acc = '0;
   bit          p_ovf = 1'b0;
   logic [63:0] sv;
   bit          carry;
   int          cyc = 0;
   bit          started = 1'b0;

   always @(posedge clk) begin
      cyc++;
      if (rst) begin
         m_busy  = 1'b0;
         m_k     = 0;
         m_acc   = '0;
         m_ovf   = 1'b0;
         started = 1'b1;
      end else if (!m_busy) begin
         if (in_valid) begin
            sv    = (clr ? 64'd0 : {32'd0, m_acc}) + 64'(a) * 64'(b);
            carry = sv[32];
`ifdef MAC_ACC_SATURATE_EN
            p_acc = carry ? 32'hFFFF_FFFF : sv[31:0];
`else
            p_acc = sv[31:0];
`endif
            p_ovf  = clr ? carry : (m_ovf | carry);
            m_busy = 1'b1;
            m_k    = 1;
         end
      end else if (m_k == LAT) begin
         m_busy = 1'b0;
      end else begin
         m_k++;
         if (m_k == LAT) begin
            m_acc = p_acc;
            m_ovf = p_ovf;
         end
      end
   end

   typedef struct {
      int          cyc;
      logic [31:0] acc;
      bit          ovf;
      bit          snap;
      string       nm;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;
   int   timeouts = 0;
   bit   done = 1'b0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s cycle=%0d got=%0h expected=%0h", nm, cyc, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (started) begin
         chk("in_ready", in_ready, !m_busy);
         chk("out_valid", out_valid, m_busy && (m_k == LAT));
         chk("acc_out", acc_out, m_acc);
         chk("overflow", overflow, m_ovf);
         if (exp_q.size() > 0) begin
            if (exp_q[0].snap && cyc == exp_q[0].cyc) begin
               chk({exp_q[0].nm, "_acc"}, acc_out, exp_q[0].acc);
               chk({exp_q[0].nm, "_ovf"}, overflow, exp_q[0].ovf);
               chk({exp_q[0].nm, "_ready"}, in_ready, 1);
               chk({exp_q[0].nm, "_no_pulse"}, out_valid, 0);
               void'(exp_q.pop_front());
            end else if (!exp_q[0].snap && out_valid) begin
               chk({exp_q[0].nm, "_cycle"}, cyc, exp_q[0].cyc);
               chk({exp_q[0].nm, "_acc"}, acc_out, exp_q[0].acc);
               chk({exp_q[0].nm, "_ovf"}, overflow, exp_q[0].ovf);
               void'(exp_q.pop_front());
            end
         end
      end
      if (done) begin
         chk("literals_drained", exp_q.size(), 0);
         chk("wait_timeouts", timeouts, 0);
         $display("Result: errors=%0d of %0d checks", errors, checks);
         $finish;
      end
   end

   task automatic wait_idle();
      int n = 0;
      while (!in_ready && n < 200) begin
         in_valid = 1'($urandom_range(0, 1));
         a        = DW'($urandom);
         b        = DW'($urandom);
         clr      = 1'($urandom);
         @(negedge clk);
         n++;
      end
      if (!in_ready) timeouts++;
   endtask

   task automatic send(input logic [DW-1:0] x, input logic [DW-1:0] y, input logic c,
                       input bit lit, input logic [31:0] eacc, input bit eovf, input string nm);
      wait_idle();
      a        = x;
      b        = y;
      clr      = c;
      in_valid = 1'b1;
      if (lit) exp_q.push_back('{cyc + LAT, eacc, eovf, 1'b0, nm});
      @(negedge clk);
      in_valid = 1'b0;
      a        = DW'($urandom);
      b        = DW'($urandom);
      clr      = 1'($urandom);
   endtask

   initial begin
      int t0;
      int n;
      logic [DW-1:0] x;
      logic [DW-1:0] y;

      rst      = 1'b1;
      in_valid = 1'b1;
      a        = 16'd5;
      b        = 16'd5;
      clr      = 1'b1;
      repeat (3) @(negedge clk);
      rst      = 1'b0;
      in_valid = 1'b0;
      exp_q.push_back('{cyc + 1, 32'd0, 1'b0, 1'b1, "reset"});
      @(negedge clk);

      send(16'd3, 16'd5, 1'b1, 1, 32'd15, 1'b0, "op_3x5");
      send(16'd4, 16'd6, 1'b0, 1, 32'd39, 1'b0, "op_4x6");
      send(16'hFFFF, 16'hFFFF, 1'b1, 1, 32'hFFFE_0001, 1'b0, "op_max_clr");
`ifdef MAC_ACC_SATURATE_EN
      send(16'hFFFF, 16'hFFFF, 1'b0, 1, 32'hFFFF_FFFF, 1'b1, "op_max_sat");
`else
      send(16'hFFFF, 16'hFFFF, 1'b0, 1, 32'hFFFC_0002, 1'b1, "op_max_wrap");
`endif
      send(16'd1, 16'd1, 1'b1, 1, 32'd1, 1'b0, "op_clr_ovf");
      send(16'd0, 16'd1234, 1'b0, 1, 32'd1, 1'b0, "op_zero");

      send(16'd7, 16'd9, 1'b1, 0, 32'd0, 1'b0, "op_abort");
      t0 = cyc - 1;
      while (cyc < t0 + 5) @(negedge clk);
      rst = 1'b1;
      exp_q.push_back('{t0 + 6, 32'd0, 1'b0, 1'b1, "abort_snap"});
      @(negedge clk);
      rst = 1'b0;

      wait_idle();
      t0       = cyc;
      a        = 16'd2;
      b        = 16'd2;
      clr      = 1'b1;
      in_valid = 1'b1;
      exp_q.push_back('{t0 + LAT, 32'd4, 1'b0, 1'b0, "b2b_first"});
      exp_q.push_back('{t0 + DW + 3 + LAT, 32'd10004, 1'b0, 1'b0, "b2b_second"});
      @(negedge clk);
      a   = 16'd100;
      b   = 16'd100;
      clr = 1'b0;
      n   = 0;
      while (!in_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) timeouts++;
      @(negedge clk);
      in_valid = 1'b0;

      for (int i = 0; i < 60; i++) begin
         x = ($urandom_range(0, 3) == 0) ? DW'(16'hFFFF - $urandom_range(0, 255)) : DW'($urandom);
         y = ($urandom_range(0, 3) == 0) ? DW'(16'hFFFF - $urandom_range(0, 255)) : DW'($urandom);
         if ($urandom_range(0, 9) == 0) x = '0;
         send(x, y, 1'($urandom_range(0, 3) == 0), 0, 32'd0, 1'b0, "rand");
         repeat ($urandom_range(0, 24)) @(negedge clk);
         if ($urandom_range(0, 7) == 0) begin
            rst      = 1'b1;
            in_valid = 1'($urandom);
            @(negedge clk);
            rst      = 1'b0;
            in_valid = 1'b0;
         end
      end

      wait_idle();
      repeat (2) @(negedge clk);
      done = 1'b1;
   end

   initial begin
      #500000;
      $display("FAIL watchdog cycle=%0d got=running expected=finished", cyc);
      $fatal(1, "watchdog expired");
   end

endmodule
